csa_accumulator: RTL and testbench
==================================

# csa_accumulator

Streaming multi-operand accumulator that consumes one operand per cycle and keeps the running total in carry-save form. Each accepted operand is folded in through one full-adder row, with no carry propagation in the loop. A final ripple-carry stage resolves the total on a `last` marker. The block sits downstream of operand producers and returns a single binary sum per batch, with a sticky overflow flag.

## Interface
- `WIDTH`, default 4: operand width in bits.
- `ACC_W`, default 6: accumulator and result width in bits. Must satisfy `ACC_W >= WIDTH`.
- `CNT_W`, default 4: width of the operand counter.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `in_valid`  in  1  operand `A` is valid.
- `in_ready`  out  1  block accepts an operand this cycle.
- `A`  in  WIDTH  unsigned operand, zero-extended to ACC_W.
- `in_last`  in  1  qualifies `A` as the final operand of the batch.
- `out_valid`  out  1  `S`, `Cout` and `N` hold the batch result.
- `out_ready`  in  1  consumer takes the result.
- `S`  out  ACC_W  resolved sum, modulo 2^ACC_W.
- `Cout`  out  1  sticky overflow: true batch sum ≥ 2^ACC_W.
- `N`  out  CNT_W  operands accepted in the batch, saturating at 2^CNT_W−1.

## Operation
- Internal state:
  - `sum_r[ACC_W]` and `carry_r[ACC_W]`: redundant accumulator.
  - `ovf_r`: sticky overflow bit.
  - `cnt_r[CNT_W]`: operand count.
  - FSM with states ACCUM, RESOLVE and DONE.
- ACCUM:
  - `in_ready`=1 and `out_valid`=0.
  - On `in_valid&&in_ready`, for every bit i: `sum_r[i]` ← A[i]^sum_r[i]^carry_r[i], and m[i] = maj(A[i],sum_r[i],carry_r[i]).
  - `carry_r` ← {m[ACC_W−2:0],0}.
  - `ovf_r` ← `ovf_r` | m[ACC_W−1]; the dropped carry is worth 2^ACC_W.
  - `cnt_r` increments and saturates.
  - If `in_last`=1, next state is RESOLVE; otherwise stay in ACCUM.
- RESOLVE:
  - `in_ready`=0 and `out_valid`=0; lasts exactly one cycle.
  - Ripple-add `sum_r`+`carry_r` with cin=0.
  - `S` ← low ACC_W bits of the addition.
  - `Cout` ← `ovf_r` | ripple carry-out.
  - `N` ← `cnt_r`.
  - Next state is DONE.
- DONE:
  - `out_valid`=1 and `in_ready`=0.
  - `S`, `Cout` and `N` are held stable.
  - On `out_ready`=1: clear `sum_r`, `carry_r`, `ovf_r` and `cnt_r`, then go to ACCUM. `S`, `Cout` and `N` keep their values until the next RESOLVE.
- Overflow detection is exact: true sum = sum_r + carry_r + 2^ACC_W·(number of dropped carries).
- Every batch contains at least one operand, because `in_last` is only sampled with `in_valid`.
- `in_last` sampled without `in_valid` is ignored.
- Reset (`rst_n`=0, at any time including mid-batch or in DONE):
  - All registers clear immediately: `sum_r`=`carry_r`=0, `ovf_r`=0, `cnt_r`=0, FSM=ACCUM.
  - Outputs: `S`=0, `Cout`=0, `N`=0, `out_valid`=0, `in_ready`=1 while and after reset.

## Timing
- Throughput while in ACCUM: one operand per cycle. The compress path is one full-adder deep, independent of ACC_W.
- Latency: last operand accepted at edge k → RESOLVE during cycle k..k+1 → `out_valid`=1 after edge k+1.
- `out_valid` remains high until the edge at which `out_ready`=1. `in_ready` rises after that same edge.
- Minimum batch period is operand count + 2 cycles when `out_ready` is tied high.
- `in_ready` and `out_valid` are decoded from FSM state only. There are no combinational paths from `in_valid` or `out_ready` to outputs.
- If `A`/`in_valid` are held while `in_ready`=0, the operand is not consumed. The producer keeps it until `in_ready`=1.

## Test plan
- WIDTH=4, ACC_W=6. Operands 15, 15, 15, 15 (last on the 4th) → `S`=60, `Cout`=0, `N`=4, `out_valid` rises two edges after the 4th accept.
- Operands 15×5 → true sum 75: `S`=11, `Cout`=1, `N`=5. Then a new batch of 3, 4 (last) → `S`=7, `Cout`=0, `N`=2, which proves the sticky state was cleared.
- Single operand 9 with `in_last`=1 → `S`=9, `Cout`=0, `N`=1.
- Backpressure: batch 1, 2 (last) with `out_ready` held low for 3 cycles and the next operand held on `A`/`in_valid`:
  - `out_valid`, `S`=3 and `N`=2 stay stable for the whole stall.
  - `in_ready`=0 throughout, and the held operand is not consumed.
  - Once `out_ready` rises, the held operand is accepted on the cycle after the handshake edge.
- Reset mid-batch: after operands 7, 8, pulse `rst_n` low asynchronously between edges → `S`=0, `Cout`=0, `N`=0, `out_valid`=0, `in_ready`=1 immediately. A following batch of 5 (last) → `S`=5.
- Randomized batches of 1–20 operands compared against a reference sum:
  - `S` must equal the sum mod 64.
  - `Cout` must equal (sum ≥ 64).
  - `N` must equal min(count, 15).

Source files
------------

// File: rtl/csa_accumulator.sv
// Streaming accumulator: running total kept in carry-save form, one full-adder row per operand,
// resolved by a single ripple-carry pass when the batch's last operand has been folded in.
module csa_accumulator #(
  parameter int WIDTH = 4,
  parameter int ACC_W = 6,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] S,
  output logic             Cout,
  output logic [CNT_W-1:0] N
);

  typedef enum logic [1:0] {ACCUM, RESOLVE, DONE} state_e;

  state_e           state_q;
  logic [ACC_W-1:0] sum_q, carry_q;
  logic             ovf_q;
  logic [CNT_W-1:0] cnt_q;
  logic [ACC_W-1:0] s_q;
  logic             cout_q;
  logic [CNT_W-1:0] n_q;

  logic [ACC_W-1:0] a_ext;
  logic [ACC_W-1:0] sum_d, maj_d, carry_d;
  logic             ovf_d;
  logic [CNT_W-1:0] cnt_d;
  logic [ACC_W:0]   res_d;

  function automatic logic [ACC_W:0] ripple_add(input logic [ACC_W-1:0] x,
                                                input logic [ACC_W-1:0] y);
    logic [ACC_W-1:0] s;
    logic             c;
    c = 1'b0;
    s = '0;
    for (int i = 0; i < ACC_W; i++) begin
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    return {c, s};
  endfunction

  // One 3:2 compressor row; the carry shifted out of the top bit is worth 2^ACC_W.
  always_comb begin
    a_ext   = ACC_W'(A);
    sum_d   = a_ext ^ sum_q ^ carry_q;
    maj_d   = (a_ext & sum_q) | (a_ext & carry_q) | (sum_q & carry_q);
    carry_d = {maj_d[ACC_W-2:0], 1'b0};
    ovf_d   = ovf_q | maj_d[ACC_W-1];
    cnt_d   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
    res_d   = ripple_add(sum_q, carry_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      sum_q   <= '0;
      carry_q <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      n_q     <= '0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (in_valid) begin
            sum_q   <= sum_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
            if (in_last) state_q <= RESOLVE;
          end
        end
        RESOLVE: begin
          s_q     <= res_d[ACC_W-1:0];
          cout_q  <= ovf_q | res_d[ACC_W];
          n_q     <= cnt_q;
          state_q <= DONE;
        end
        DONE: begin
          // Results stay on S/Cout/N after the handshake until the next resolve.
          if (out_ready) begin
            sum_q   <= '0;
            carry_q <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            state_q <= ACCUM;
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign S         = s_q;
  assign Cout      = cout_q;
  assign N         = n_q;

endmodule

// File: tb/tb_csa_accumulator.sv
// Scoreboard bench for csa_accumulator: stimulus pushes expected batch results, a monitor pops them.
module tb_csa_accumulator;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] A;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] S;
  logic       Cout;
  logic [3:0] N;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [5:0] s;
    logic       c;
    logic [3:0] n;
  } exp_t;

  exp_t exp_q[$];
  bit   seen;

  csa_accumulator #(.WIDTH(4), .ACC_W(6), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .A(A),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .S(S), .Cout(Cout), .N(N)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input int s, input int c, input int n);
    exp_t e;
    e.s = 6'(s);
    e.c = 1'(c);
    e.n = 4'(n);
    exp_q.push_back(e);
  endtask

  // Monitor: compare each presented result once against the scoreboard head.
  always @(negedge clk) begin
    if (!rst_n) begin
      seen = 1'b0;
    end else if (!out_valid) begin
      seen = 1'b0;
    end else if (!seen) begin
      seen = 1'b1;
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("S", int'(S), int'(e.s));
        chk("Cout", int'(Cout), int'(e.c));
        chk("N", int'(N), int'(e.n));
      end
    end
  end

  task automatic send(input int a, input bit last);
    int guard;
    guard = 0;
    @(negedge clk);
    A        = 4'(a);
    in_valid = 1'b1;
    in_last  = last;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) chk("send_timeout", 0, 1);
    @(posedge clk);
  endtask

  task automatic idle_until_ready();
    int guard;
    guard = 0;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) chk("ready_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    int sum;
    int cnt;
    int v;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    A         = '0;
    out_ready = 1'b1;
    seen      = 1'b0;
    #12;
    chk("rst_S", int'(S), 0);
    chk("rst_Cout", int'(Cout), 0);
    chk("rst_N", int'(N), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;

    // 15 x4 = 60, with latency check on out_valid.
    push_exp(60, 0, 4);
    send(15, 0); send(15, 0); send(15, 0); send(15, 1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("lat_resolve_out_valid", int'(out_valid), 0);
    chk("lat_resolve_in_ready", int'(in_ready), 0);
    @(negedge clk);
    chk("lat_done_out_valid", int'(out_valid), 1);
    idle_until_ready();

    // 15 x5 = 75 -> 11 with overflow, then 3+4 clears sticky state.
    push_exp(11, 1, 5);
    for (int i = 0; i < 4; i++) send(15, 0);
    send(15, 1);
    idle_until_ready();
    push_exp(7, 0, 2);
    send(3, 0); send(4, 1);
    idle_until_ready();

    // Single operand batch.
    push_exp(9, 0, 1);
    send(9, 1);
    idle_until_ready();

    // Backpressure: result held three cycles while the next operand waits on A.
    out_ready = 1'b0;
    push_exp(3, 0, 2);
    push_exp(5, 0, 1);
    send(1, 0); send(2, 1);
    @(negedge clk);
    A        = 4'd5;
    in_valid = 1'b1;
    in_last  = 1'b1;
    guard = 0;
    while (!out_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("bp_out_valid_rise", int'(out_valid), 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_out_valid", int'(out_valid), 1);
      chk("bp_S", int'(S), 3);
      chk("bp_N", int'(N), 2);
      chk("bp_in_ready", int'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_after_hs_in_ready", int'(in_ready), 1);
    chk("bp_after_hs_out_valid", int'(out_valid), 0);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("bp_held_consumed", int'(in_ready), 0);
    idle_until_ready();

    // Asynchronous reset in the middle of a batch.
    send(7, 0); send(8, 0);
    #3;
    rst_n = 1'b0;
    #1;
    in_valid = 1'b0;
    chk("mid_rst_S", int'(S), 0);
    chk("mid_rst_Cout", int'(Cout), 0);
    chk("mid_rst_N", int'(N), 0);
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_in_ready", int'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    push_exp(5, 0, 1);
    send(5, 1);
    idle_until_ready();

    // Random batches against a reference sum.
    for (int b = 0; b < 8; b++) begin
      cnt = int'($urandom_range(1, 20));
      sum = 0;
      for (int k = 0; k < cnt; k++) begin
        v = int'($urandom_range(0, 15));
        sum += v;
        if (k == 0) push_exp(0, 0, 0);
        send(v, (k == cnt - 1));
      end
      exp_q[exp_q.size() - 1] = {6'(sum % 64), (sum >= 64), 4'((cnt > 15) ? 15 : cnt)};
      idle_until_ready();
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
